fall_window_sequencer: RTL and testbench

- Sequences the fall-detection datapath.
- Requests a window of accelerometer samples from the I2C reader and buffers WIN_LEN 16-bit samples.
- Scans the buffer one sample per cycle against the 0.8g/1g band and counts out-of-band hits.
- Drives the active-low LED alarm with a retriggerable hold time.
- Sits between the I2C sample reader and the LED pin; replaces the free-running flag/done counter with an explicit handshake.

---
 rtl/fall_pkg.sv | 24 ++
 rtl/window_buffer.sv | 27 ++
 rtl/fall_window_sequencer.sv | 140 ++++++++++++++
 tb/tb_fall_window_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fall_pkg.sv
// Shared types and constants for the fall-detection sequencer: FSM states,
// sample width, default band edges and the out-of-band test.
package fall_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic [SAMPLE_W-1:0] LOWER_LIMIT_DEF = 16'h3333;  // 0.8g
  localparam logic [SAMPLE_W-1:0] UPPER_LIMIT_DEF = 16'h3FFF;  // 1g

  typedef enum logic [1:0] {
    REQ,
    FILL,
    SCAN,
    DECIDE
  } state_t;

  // Both band edges count as hits.
  function automatic logic out_of_band(input logic [SAMPLE_W-1:0] sample,
                                       input logic [SAMPLE_W-1:0] lo,
                                       input logic [SAMPLE_W-1:0] hi);
    return (sample <= lo) || (sample >= hi);
  endfunction

endpackage

// File: rtl/window_buffer.sv
// WIN_LEN x SAMPLE_W register file: one synchronous write port and one
// combinational read port.
module window_buffer
  import fall_pkg::*;
#(
  parameter int WIN_LEN = 5,
  parameter int IDX_W   = 3
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [IDX_W-1:0]    raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [WIN_LEN];

  // NOTE: no reset on the storage array; every entry is rewritten before it
  // is read, so clearing it would only cost flops and reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fall_window_sequencer.sv
// Fall-detection sequencer: fills a window of samples, counts out-of-band
// hits, decides and drives a retriggerable active-low alarm.
// Define FALL_DEBOUNCE_EN to require two consecutive qualifying windows.
module fall_window_sequencer
  import fall_pkg::*;
#(
  parameter int                  WIN_LEN     = 5,
  parameter int                  MIN_HITS    = 2,
  parameter logic [SAMPLE_W-1:0] LOWER_LIMIT = LOWER_LIMIT_DEF,
  parameter logic [SAMPLE_W-1:0] UPPER_LIMIT = UPPER_LIMIT_DEF,
  parameter int                  HOLD_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                acq_req,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_ready,
  output logic                busy,
  output logic                fall_pulse,
  output logic [5:0]          hit_count,
  output logic                alarm_n
);

  localparam int               IDX_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int               HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  state_t              state;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [5:0]          acc;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [SAMPLE_W-1:0] rd_data;
  logic                accept;
  logic                qualify;
  logic                fire;

  // sample_ready is only ever high in FILL, so this is the FILL-state accept.
  assign accept  = sample_valid && sample_ready;
  assign qualify = (acc >= 6'(MIN_HITS));

`ifdef FALL_DEBOUNCE_EN
  logic prev_hit;

  assign fire = (state == DECIDE) && qualify && prev_hit;

  always_ff @(posedge clk) begin
    if (rst)                  prev_hit <= 1'b0;
    else if (state == DECIDE) prev_hit <= qualify;
  end
`else
  assign fire = (state == DECIDE) && qualify;
`endif

  window_buffer #(
    .WIN_LEN (WIN_LEN),
    .IDX_W   (IDX_W)
  ) u_window_buffer (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_idx),
    .wdata (sample_data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= REQ;
      acq_req      <= 1'b0;
      sample_ready <= 1'b0;
      busy         <= 1'b0;
      fall_pulse   <= 1'b0;
      hit_count    <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      acc          <= '0;
    end else begin
      fall_pulse <= 1'b0;
      unique case (state)
        REQ: begin
          state        <= FILL;
          acq_req      <= 1'b1;
          sample_ready <= 1'b1;
          busy         <= 1'b1;
        end
        FILL: begin
          if (accept) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx       <= '0;
              acq_req      <= 1'b0;
              sample_ready <= 1'b0;
              state        <= SCAN;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        SCAN: begin
          if (out_of_band(rd_data, LOWER_LIMIT, UPPER_LIMIT) && (acc != 6'd63))
            acc <= acc + 6'd1;
          if (rd_idx == LAST_IDX) begin
            rd_idx <= '0;
            state  <= DECIDE;
          end else begin
            rd_idx <= rd_idx + 1'b1;
          end
        end
        DECIDE: begin
          hit_count  <= acc;
          fall_pulse <= fire;
          acc        <= '0;
          acq_req    <= 1'b1;
          busy       <= 1'b0;
          state      <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  // Alarm hold runs independently of the FSM; a reload beats the final
  // decrement so alarm_n never blips high on a retrigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      alarm_n  <= 1'b1;
    end else if (fire) begin
      hold_cnt <= HOLD_W'(HOLD_CYCLES);
      alarm_n  <= 1'b0;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
      alarm_n  <= (hold_cnt == HOLD_W'(1));
    end
  end

endmodule

// File: tb/tb_fall_window_sequencer.sv
// Scoreboard bench for fall_window_sequencer: a driver feeds windows with
// random gaps and noise, a monitor checks each decision and the alarm level.
module tb_fall_window_sequencer;

  localparam int          WIN_LEN  = 5;
  localparam int          MIN_HITS = 2;
  localparam int          HOLD     = 1000;
  localparam logic [15:0] LO       = 16'h3333;
  localparam logic [15:0] HI       = 16'h3FFF;

  typedef struct {
    int hits;
    bit fall;
    int due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acq_req;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data  = '0;
  logic        sample_ready;
  logic        busy;
  logic        fall_pulse;
  logic [5:0]  hit_count;
  logic        alarm_n;

  int   checks      = 0;
  int   failures    = 0;
  int   cyc         = 0;
  bit   rst_q       = 1'b1;
  bit   busy_prev   = 1'b0;
  int   alarm_until = 0;
  bit   prev_q      = 1'b0;
  exp_t exp_q[$];
  logic [15:0] acc_q[$];
  logic [15:0] win [WIN_LEN];

  fall_window_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .acq_req      (acq_req),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .busy         (busy),
    .fall_pulse   (fall_pulse),
    .hit_count    (hit_count),
    .alarm_n      (alarm_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a full window of accepted samples yields one decision.
  task automatic model_accept(input logic [15:0] s);
    int   hits;
    bit   q;
    exp_t e;
    acc_q.push_back(s);
    if (acc_q.size() == WIN_LEN) begin
      hits = 0;
      foreach (acc_q[k]) if (acc_q[k] <= LO || acc_q[k] >= HI) hits++;
      q = (hits >= MIN_HITS);
`ifdef FALL_DEBOUNCE_EN
      e.fall = q && prev_q;
`else
      e.fall = q;
`endif
      prev_q = q;
      e.hits = hits;
      e.due  = cyc + WIN_LEN + 2;
      exp_q.push_back(e);
      acc_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rst          = 1'b0;
      sample_valid = 1'b0;
      sample_data  = 16'($urandom);
    end
  endtask

  // Offers win[] one sample at a time; abort_after >= 0 pulses rst after
  // that many accepts and drops the rest of the window.
  task automatic run_window(input int max_gap, input bit noise, input int abort_after);
    int i     = 0;
    int guard = 0;
    int gap   = int'($urandom_range(max_gap, 0));
    while (i < WIN_LEN) begin
      @(negedge clk);
      rst = 1'b0;
      if (++guard > 200) begin
        checks++;
        failures++;
        $display("FAIL window_timeout: accepted %0d of %0d samples", i, WIN_LEN);
        return;
      end
      if (abort_after >= 0 && i == abort_after) begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        acc_q.delete();
        prev_q = 1'b0;
        return;
      end
      if (sample_ready) begin
        if (gap > 0) begin
          sample_valid = 1'b0;
          sample_data  = 16'($urandom);
          gap--;
        end else begin
          sample_valid = 1'b1;
          sample_data  = win[i];
          model_accept(win[i]);
          i++;
          gap = int'($urandom_range(max_gap, 0));
        end
      end else begin
        sample_valid = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        sample_data  = 16'($urandom);
      end
    end
  endtask

  // Monitor: reset values while in reset, scoreboard pop on every decision,
  // and the alarm level every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      check("rst_acq_req", acq_req, 0);
      check("rst_sample_ready", sample_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_fall_pulse", fall_pulse, 0);
      check("rst_hit_count", hit_count, 0);
      check("rst_alarm_n", alarm_n, 1);
      busy_prev   = 1'b0;
      alarm_until = 0;
    end else begin
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_decision: hit_count %0d at cycle %0d", hit_count, cyc);
        end else begin
          e = exp_q.pop_front();
          check("hit_count", hit_count, e.hits);
          check("fall_pulse", fall_pulse, e.fall);
          check("decision_cycle", cyc, e.due);
          check("acq_req_after_decide", acq_req, 1);
          if (e.fall) alarm_until = cyc + HOLD;
        end
      end else begin
        check("fall_pulse_idle", fall_pulse, 0);
      end
      check("alarm_n", alarm_n, (cyc < alarm_until) ? 0 : 1);
      busy_prev = busy;
    end
  end

  initial begin
    logic [15:0] edges [4];
    int sel;
    edges = '{16'h3333, 16'h3334, 16'h3FFE, 16'h3FFF};

    idle(3);
    rst = 1'b1;
    @(negedge clk);

    win = '{16'h3800, 16'h3800, 16'h3800, 16'h3800, 16'h3800};
    run_window(0, 1'b0, -1);

    // Two qualifying windows back to back: retrigger, then a full hold.
    win = '{16'h3800, 16'h1000, 16'h3800, 16'h4000, 16'h3800};
    run_window(0, 1'b0, -1);
    run_window(0, 1'b0, -1);
    idle(HOLD + 100);

    win = '{16'h3333, 16'h3FFF, 16'h3334, 16'h3FFE, 16'h3800};
    run_window(0, 1'b0, -1);
    win = '{16'h3334, 16'h3FFE, 16'h3800, 16'h3800, 16'h3800};
    run_window(0, 1'b0, -1);

    win = '{16'h3800, 16'h1000, 16'h3800, 16'h4000, 16'h3800};
    run_window(3, 1'b1, -1);
    run_window(3, 1'b1, -1);

    // Abort a partial window, then a fresh qualifying one.
    run_window(0, 1'b0, 3);
    run_window(1, 1'b1, -1);
    idle(50);

    repeat (10) begin
      for (int k = 0; k < WIN_LEN; k++) begin
        sel = int'($urandom_range(3, 0));
        case (sel)
          0:       win[k] = 16'($urandom_range(32'h3333, 0));
          1:       win[k] = 16'($urandom_range(32'hFFFF, 32'h3FFF));
          2:       win[k] = 16'($urandom_range(32'h3FFE, 32'h3334));
          default: win[k] = edges[$urandom_range(3, 0)];
        endcase
      end
      run_window(3, 1'b1, -1);
    end

    for (int k = 0; k < 3000 && (exp_q.size() != 0 || cyc < alarm_until + 2); k++) idle(1);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d decisions still outstanding", exp_q.size());
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
